// File: rtl/icache_line_buf.sv
// Direct-mapped instruction line buffer between prefetch and instruction memory, with line refill, kill and flush.
// Optional hit/miss performance counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_line_buf #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pf2icache_req_i,
   input  logic [ADDR_W-1:0] pf2icache_addr_i,
   input  logic              pf2icache_kill_i,
   input  logic              pf2icache_flush_i,
   output logic              icache2pf_ack_o,
   output logic [DATA_W-1:0] icache2pf_r_data_o,
   output logic              icache2mem_req_o,
   output logic [ADDR_W-1:0] icache2mem_addr_o,
   input  logic              mem2icache_ack_i,
   input  logic [DATA_W-1:0] mem2icache_r_data_i
`ifdef ICACHE_PERF_CNT_EN
   ,
   output logic [31:0]       perf_hit_cnt_o,
   output logic [31:0]       perf_miss_cnt_o
`endif
);

   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int LO    = OFF_W + 2;
   localparam int TAG_W = ADDR_W - LO - IDX_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [NUM_LINES-1:0] valid_r;
   logic [TAG_W-1:0]  tag_r      [NUM_LINES];
   logic [DATA_W-1:0] data_r     [NUM_LINES*LINE_WORDS];
   logic [DATA_W-1:0] line_buf_r [LINE_WORDS];
   logic [OFF_W-1:0]  beat_r;
   logic [OFF_W-1:0]  req_off_r;
   logic [IDX_W-1:0]  req_idx_r;
   logic [TAG_W-1:0]  req_tag_r;
   logic              kill_r;
   logic              noalloc_r;

   logic [OFF_W-1:0]  lk_off_s;
   logic [IDX_W-1:0]  lk_idx_s;
   logic [TAG_W-1:0]  lk_tag_s;
   logic              hit_s;
   logic              lookup_s;
   logic              last_beat_s;
   logic              abort_s;
   logic              alloc_s;
   logic              unused_addr_s;

   assign lk_off_s      = pf2icache_addr_i[LO-1:2];
   assign lk_idx_s      = pf2icache_addr_i[LO+IDX_W-1:LO];
   assign lk_tag_s      = pf2icache_addr_i[ADDR_W-1:LO+IDX_W];
   assign unused_addr_s = ^pf2icache_addr_i[1:0];
   assign hit_s         = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
   // The ack cycle itself is excluded so a still-held request is not answered twice.
   assign lookup_s      = (state_r == ST_IDLE) && pf2icache_req_i && !pf2icache_kill_i && !icache2pf_ack_o;
   assign last_beat_s   = (beat_r == OFF_W'(LINE_WORDS - 1));
   assign abort_s       = kill_r || pf2icache_kill_i;
   assign alloc_s       = !noalloc_r && !pf2icache_flush_i;

   // Next-state selection for the lookup / refill / respond sequence.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (lookup_s && !hit_s) state_s = ST_FILL;
            else                    state_s = ST_IDLE;
         end
         ST_FILL: begin
            if (!mem2icache_ack_i) state_s = ST_FILL;
            else if (abort_s)      state_s = ST_IDLE;
            else if (last_beat_s)  state_s = ST_RESP;
            else                   state_s = ST_FILL;
         end
         ST_RESP: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= state_s;
   end

   // Control registers, valid bits and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_r            <= {NUM_LINES{1'b0}};
         icache2pf_ack_o    <= 1'b0;
         icache2pf_r_data_o <= {DATA_W{1'b0}};
         icache2mem_req_o   <= 1'b0;
         icache2mem_addr_o  <= {ADDR_W{1'b0}};
         beat_r             <= {OFF_W{1'b0}};
         req_off_r          <= {OFF_W{1'b0}};
         req_idx_r          <= {IDX_W{1'b0}};
         req_tag_r          <= {TAG_W{1'b0}};
         kill_r             <= 1'b0;
         noalloc_r          <= 1'b0;
      end else begin
         icache2pf_ack_o <= 1'b0;
         if (pf2icache_flush_i) valid_r <= {NUM_LINES{1'b0}};
         case (state_r)
            ST_IDLE: begin
               if (lookup_s && hit_s) begin
                  icache2pf_ack_o    <= 1'b1;
                  icache2pf_r_data_o <= data_r[{lk_idx_s, lk_off_s}];
               end else if (lookup_s) begin
                  icache2mem_req_o  <= 1'b1;
                  icache2mem_addr_o <= {pf2icache_addr_i[ADDR_W-1:LO], {LO{1'b0}}};
                  beat_r            <= {OFF_W{1'b0}};
                  req_off_r         <= lk_off_s;
                  req_idx_r         <= lk_idx_s;
                  req_tag_r         <= lk_tag_s;
                  kill_r            <= 1'b0;
                  noalloc_r         <= 1'b0;
               end
            end
            ST_FILL: begin
               if (pf2icache_kill_i)  kill_r    <= 1'b1;
               if (pf2icache_flush_i) noalloc_r <= 1'b1;
               if (mem2icache_ack_i) begin
                  if (abort_s || last_beat_s) begin
                     icache2mem_req_o <= 1'b0;
                  end else begin
                     beat_r            <= beat_r + OFF_W'(1);
                     // Only the word-offset field advances, so beats never leave the line.
                     icache2mem_addr_o <= {icache2mem_addr_o[ADDR_W-1:LO], beat_r + OFF_W'(1), 2'b00};
                  end
                  if (!abort_s && last_beat_s && alloc_s) valid_r[req_idx_r] <= 1'b1;
                  if (abort_s) begin
                     kill_r    <= 1'b0;
                     noalloc_r <= 1'b0;
                  end
               end
            end
            ST_RESP: begin
               icache2pf_ack_o    <= !pf2icache_kill_i;
               icache2pf_r_data_o <= line_buf_r[req_off_r];
               kill_r             <= 1'b0;
               noalloc_r          <= 1'b0;
            end
            default: begin
               icache2mem_req_o <= 1'b0;
            end
         endcase
      end
   end

   // Refill line buffer, and tag/data array write when a completed line is allocated.
   always_ff @(posedge clk) begin
      if ((state_r == ST_FILL) && mem2icache_ack_i) begin
         line_buf_r[beat_r] <= mem2icache_r_data_i;
         if (!abort_s && last_beat_s && alloc_s) begin
            tag_r[req_idx_r] <= req_tag_r;
            for (int w = 0; w < LINE_WORDS; w++) begin
               data_r[{req_idx_r, OFF_W'(w)}] <= (OFF_W'(w) == beat_r) ? mem2icache_r_data_i : line_buf_r[w];
            end
         end
      end
   end

`ifdef ICACHE_PERF_CNT_EN
   // Saturating hit and miss counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_hit_cnt_o  <= 32'd0;
         perf_miss_cnt_o <= 32'd0;
      end else begin
         if (lookup_s && hit_s && (perf_hit_cnt_o != 32'hFFFF_FFFF))
            perf_hit_cnt_o <= perf_hit_cnt_o + 32'd1;
         if (lookup_s && !hit_s && (perf_miss_cnt_o != 32'hFFFF_FFFF))
            perf_miss_cnt_o <= perf_miss_cnt_o + 32'd1;
      end
   end
`else
   // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_icache_line_buf.sv
// Directed self-checking bench for icache_line_buf; memory model returns ~addr two cycles after a beat request.
module tb_icache_line_buf;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pf_req = 1'b0;
   logic [31:0] pf_addr = 32'h0;
   logic        pf_kill = 1'b0;
   logic        pf_flush = 1'b0;
   logic        ack;
   logic [31:0] rdata;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   int          total = 0;
   int          bad = 0;
   int          stray_req = 0;
   int          stray_done = 0;
   logic [31:0] addr_log [$];

   icache_line_buf dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .pf2icache_req_i     (pf_req),
      .pf2icache_addr_i    (pf_addr),
      .pf2icache_kill_i    (pf_kill),
      .pf2icache_flush_i   (pf_flush),
      .icache2pf_ack_o     (ack),
      .icache2pf_r_data_o  (rdata),
      .icache2mem_req_o    (mem_req),
      .icache2mem_addr_o   (mem_addr),
      .mem2icache_ack_i    (mem_ack),
      .mem2icache_r_data_i (mem_rdata)
`ifdef ICACHE_PERF_CNT_EN
      ,
      .perf_hit_cnt_o      (hit_cnt),
      .perf_miss_cnt_o     (miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Memory responder: one outstanding beat, answered two cycles after the request is seen.
   initial begin
      int cnt;
      cnt = 0;
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (stray_req != stray_done) begin
            stray_done = stray_req;
            mem_ack = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
         end else if (mem_req) begin
            if (cnt == 1) begin
               mem_ack = 1'b1;
               mem_rdata = ~mem_addr;
               addr_log.push_back(mem_addr);
               cnt = 0;
            end else begin
               cnt = cnt + 1;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_log(input int n);
      for (int c = 0; c < 40 && addr_log.size() < n; c++) step();
   endtask

   // Hold the current request until ack (bounded), release it, then watch for a repeated ack.
   task automatic wait_ack(output logic [31:0] d, output int lat, output int nack);
      lat = 0;
      nack = 0;
      d = 32'h0;
      for (int c = 0; c < 60 && nack == 0; c++) begin
         step();
         lat++;
         if (ack) begin
            nack++;
            d = rdata;
         end
      end
      pf_req = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (ack) nack++;
      end
   endtask

   task automatic fetch(input logic [31:0] a, output logic [31:0] d, output int lat, output int nack);
      pf_addr = a;
      pf_req = 1'b1;
      wait_ack(d, lat, nack);
   endtask

   task automatic chk_line(input string tag, input int base, input logic [31:0] line);
      logic [31:0] v;
      chk({tag, "_beats"}, 32'(addr_log.size() - base), 32'd4);
      for (int k = 0; k < 4; k++) begin
         v = (base + k < addr_log.size()) ? addr_log[base + k] : 32'hFFFF_FFFF;
         chk({tag, "_addr"}, v, line + 32'(4 * k));
      end
   endtask

   initial begin
      logic [31:0] d;
      int          lat;
      int          nack;
      int          base;
      int          acks;

      repeat (2) step();
      chk("rst_ack", {31'd0, ack}, 32'd0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
`ifdef ICACHE_PERF_CNT_EN
      chk("rst_hit_cnt", hit_cnt, 32'd0);
      chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif
      rst_n = 1'b1;
      step();

      base = addr_log.size();
      fetch(32'h8000_0004, d, lat, nack);
      chk("cold_nack", 32'(nack), 32'd1);
      chk("cold_data", d, 32'h7FFF_FFFB);
      chk_line("cold", base, 32'h8000_0000);

      base = addr_log.size();
      fetch(32'h8000_0008, d, lat, nack);
      chk("hit_nack", 32'(nack), 32'd1);
      chk("hit_lat", 32'(lat), 32'd1);
      chk("hit_data", d, 32'h7FFF_FFF7);
      chk("hit_no_mem", 32'(addr_log.size() - base), 32'd0);
`ifdef ICACHE_PERF_CNT_EN
      chk("hit_cnt", hit_cnt, 32'd1);
      chk("miss_cnt", miss_cnt, 32'd1);
`endif

      pf_addr = 32'h8000_0000;
      pf_req = 1'b1;
      pf_kill = 1'b1;
      step();
      pf_kill = 1'b0;
      pf_req = 1'b0;
      step();
      chk("idle_kill_ack", {31'd0, ack}, 32'd0);
      chk("idle_kill_mem", {31'd0, mem_req}, 32'd0);

      base = addr_log.size();
      fetch(32'h8000_0040, d, lat, nack);
      chk("conf_a_data", d, 32'h7FFF_FFBF);
      chk_line("conf_a", base, 32'h8000_0040);
      base = addr_log.size();
      fetch(32'h8000_0000, d, lat, nack);
      chk("conf_b_data", d, 32'h7FFF_FFFF);
      chk_line("conf_b", base, 32'h8000_0000);

      base = addr_log.size();
      fetch(32'h8000_004C, d, lat, nack);
      chk("wrap_data", d, 32'h7FFF_FFB3);
      chk_line("wrap", base, 32'h8000_0040);

      base = addr_log.size();
      pf_addr = 32'h8000_0010;
      pf_req = 1'b1;
      wait_log(base + 1);
      pf_kill = 1'b1;
      pf_req = 1'b0;
      step();
      pf_kill = 1'b0;
      acks = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (ack) acks++;
      end
      chk("kill_no_ack", 32'(acks), 32'd0);
      chk("kill_mem_req", {31'd0, mem_req}, 32'd0);
      chk("kill_beats", 32'(addr_log.size() - base), 32'd2);
      base = addr_log.size();
      fetch(32'h8000_0010, d, lat, nack);
      chk("kill_rereq_data", d, 32'h7FFF_FFEF);
      chk_line("kill_rereq", base, 32'h8000_0010);

      fetch(32'h8000_0008, d, lat, nack);
      base = addr_log.size();
      fetch(32'h8000_0008, d, lat, nack);
      chk("prefl_hit_lat", 32'(lat), 32'd1);
      pf_flush = 1'b1;
      step();
      pf_flush = 1'b0;
      base = addr_log.size();
      fetch(32'h8000_0008, d, lat, nack);
      chk("flush_idle_data", d, 32'h7FFF_FFF7);
      chk_line("flush_idle", base, 32'h8000_0000);

      base = addr_log.size();
      pf_addr = 32'h8000_0024;
      pf_req = 1'b1;
      wait_log(base + 1);
      pf_flush = 1'b1;
      step();
      pf_flush = 1'b0;
      wait_ack(d, lat, nack);
      chk("flush_fill_nack", 32'(nack), 32'd1);
      chk("flush_fill_data", d, 32'h7FFF_FFDB);
      base = addr_log.size();
      fetch(32'h8000_0024, d, lat, nack);
      chk_line("flush_fill_rereq", base, 32'h8000_0020);

      pf_addr = 32'h8000_0024;
      pf_req = 1'b1;
      pf_flush = 1'b1;
      step();
      pf_flush = 1'b0;
      chk("flush_hit_ack", {31'd0, ack}, 32'd1);
      chk("flush_hit_data", rdata, 32'h7FFF_FFDB);
      pf_req = 1'b0;
      step();
      chk("flush_hit_single", {31'd0, ack}, 32'd0);
      base = addr_log.size();
      fetch(32'h8000_0024, d, lat, nack);
      chk_line("flush_hit_after", base, 32'h8000_0020);

      base = addr_log.size();
      pf_addr = 32'h8000_0030;
      pf_req = 1'b1;
      wait_log(base + 1);
      step();
      rst_n = 1'b0;
      pf_req = 1'b0;
      step();
      chk("rst_fill_mem_req", {31'd0, mem_req}, 32'd0);
      rst_n = 1'b1;
      stray_req = stray_req + 1;
      step();
      step();
      chk("stray_ack", {31'd0, ack}, 32'd0);
      chk("stray_mem_req", {31'd0, mem_req}, 32'd0);
      base = addr_log.size();
      fetch(32'h8000_0000, d, lat, nack);
      chk("rst_rereq_nack", 32'(nack), 32'd1);
      chk("rst_rereq_data", d, 32'h7FFF_FFFF);
      chk_line("rst_rereq", base, 32'h8000_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
